// File: rtl/mem_port_arbiter_if.sv
// Purpose: request/response bundle between fetch, data, memory and the shared-port arbiter.
// Latency: none; wiring only.
// Backpressure: requesters hold req until gnt; the arbiter holds mem_req until mem_gnt.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // data-memory requester
  logic                dm_req;
  logic                dm_we;
  logic [ADDR_W-1:0]   dm_addr;
  logic [DATA_W-1:0]   dm_wdata;
  logic [DATA_W/8-1:0] dm_be;
  logic                dm_gnt;
  logic                dm_rvalid;
  logic [DATA_W-1:0]   dm_rdata;
  // unified memory side
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;
  logic                busy;

  // arbiter view
  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output busy
  );

  // environment view: core requesters plus memory
  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between fetch and data; data wins unless fetch has starved STARVE_LIMIT contested grants.
// Latency: gnt c0, mem_req c1, rvalid c3 with one-cycle memory (c2 if mem_gnt and mem_rvalid coincide); one transaction in flight.
// Backpressure: grants only in IDLE; mem_req and its fields held stable until mem_gnt.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_owner_dm;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              w_dm_win;
  logic              w_if_win;
  logic              w_capture;
  logic [DATA_W-1:0] w_cap_dat;

  // Next-state and grant decode; grants are suppressed while reset is held so every output reads 0.
  always_comb begin
    w_state_nxt = r_state;
    w_dm_win    = 1'b0;
    w_if_win    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_dm_win = rst_n && bus.dm_req && (!bus.if_req || (r_starve_cnt < LIMIT));
        w_if_win = rst_n && bus.if_req && !w_dm_win;
        if (w_dm_win || w_if_win) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // a response without acceptance is not ours yet and is ignored
        if (bus.mem_gnt) begin
          if (bus.mem_rvalid) begin
            w_capture   = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Writes return zero data to the requester.
  assign w_cap_dat = r_we ? '0 : bus.mem_rdata;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the winner's fields at grant; fetch is always a full-word read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_dm <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
    end else if (w_dm_win) begin
      r_owner_dm <= 1'b1;
      r_we       <= bus.dm_we;
      r_addr     <= bus.dm_addr;
      r_wdata    <= bus.dm_wdata;
      r_be       <= bus.dm_be;
    end else if (w_if_win) begin
      r_owner_dm <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= bus.if_addr;
      r_wdata    <= '0;
      r_be       <= '1;
    end
  end

  // Count data grants that beat a waiting fetch; a fetch grant clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_dm_win && bus.if_req && (r_starve_cnt != LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end else if (w_if_win) begin
      r_starve_cnt <= '0;
    end
  end

  // Capture the response into the owner's data register; it holds until that owner's next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else if (w_capture) begin
      if (r_owner_dm) begin
        r_dm_rdata <= w_cap_dat;
      end else begin
        r_if_rdata <= w_cap_dat;
      end
    end
  end

  assign bus.if_gnt    = w_if_win;
  assign bus.dm_gnt    = w_dm_win;
  assign bus.if_rvalid = (r_state == S_RESP) && !r_owner_dm;
  assign bus.dm_rvalid = (r_state == S_RESP) && r_owner_dm;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.mem_req   = (r_state == S_ISSUE);
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_be    = r_be;
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: random and directed stimulus for mem_port_arbiter against a transaction-level reference.
// Latency: outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
// Backpressure: requesters hold until granted; memory gnt/rvalid randomised or scripted per phase.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h want=0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // reference: one outstanding transaction, tracked by progress flags
  bit            m_active, m_accepted, m_resp_due, m_owner_dm, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_rdata, m_dm_rdata;
  logic [BW-1:0] m_be;
  int            m_starve;

  // stimulus knobs
  int if_pct, dm_pct, gnt_pct, rv_pct, rv_mode;
  bit rand_rdata;
  bit g_if, g_dm;

  // directed-test observations (taken from the DUT pins)
  int            cyc;
  int            t_gnt, t_dmg, t_mreq, t_rv;
  logic [DW-1:0] rd_seen;
  logic [AW-1:0] addr_q[$];
  bit            prev_mreq, starve_chk, seen_if;
  int            run_len, n_ifg;

  task automatic check_cycle();
    bit            e_dm_gnt, e_if_gnt, e_mem_req, cap;
    logic [DW-1:0] cap_dat;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      chk("rst_if_gnt", bus.if_gnt, 0);
      chk("rst_dm_gnt", bus.dm_gnt, 0);
      chk("rst_if_rvalid", bus.if_rvalid, 0);
      chk("rst_dm_rvalid", bus.dm_rvalid, 0);
      chk("rst_if_rdata", bus.if_rdata, 0);
      chk("rst_dm_rdata", bus.dm_rdata, 0);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_mem_be", bus.mem_be, 0);
      chk("rst_busy", bus.busy, 0);
      m_active = 0; m_accepted = 0; m_resp_due = 0; m_starve = 0;
      m_if_rdata = '0; m_dm_rdata = '0;
      g_if = 0; g_dm = 0; prev_mreq = 0;
      return;
    end
    e_dm_gnt  = !m_active && bus.dm_req && (!bus.if_req || m_starve < LIM);
    e_if_gnt  = !m_active && bus.if_req && !e_dm_gnt;
    e_mem_req = m_active && !m_accepted;
    chk("dm_gnt", bus.dm_gnt, e_dm_gnt);
    chk("if_gnt", bus.if_gnt, e_if_gnt);
    chk("mem_req", bus.mem_req, e_mem_req);
    chk("busy", bus.busy, m_active);
    chk("if_rvalid", bus.if_rvalid, m_resp_due && !m_owner_dm);
    chk("dm_rvalid", bus.dm_rvalid, m_resp_due && m_owner_dm);
    chk("if_rdata", bus.if_rdata, m_if_rdata);
    chk("dm_rdata", bus.dm_rdata, m_dm_rdata);
    if (e_mem_req) begin
      chk("mem_we", bus.mem_we, m_we);
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("mem_be", bus.mem_be, m_be);
    end
    if (bus.if_gnt && t_gnt < 0) t_gnt = cyc;
    if (bus.dm_gnt && t_dmg < 0) t_dmg = cyc;
    if (bus.mem_req && t_mreq < 0) t_mreq = cyc;
    if (bus.if_rvalid && t_rv < 0) begin t_rv = cyc; rd_seen = bus.if_rdata; end
    if (bus.mem_req && !prev_mreq) addr_q.push_back(bus.mem_addr);
    prev_mreq = bus.mem_req;
    if (starve_chk) begin
      if (bus.dm_gnt) run_len++;
      if (bus.if_gnt) begin
        if (seen_if) chk("starve_run", run_len, LIM);
        seen_if = 1; run_len = 0; n_ifg++;
      end
    end
    g_if = e_if_gnt;
    g_dm = e_dm_gnt;
    // advance the reference by one clock
    if (m_resp_due) begin
      m_active = 0; m_accepted = 0; m_resp_due = 0;
    end else if (m_active) begin
      cap = 0;
      if (!m_accepted) begin
        if (bus.mem_gnt) begin m_accepted = 1; cap = bus.mem_rvalid; end
      end else begin
        cap = bus.mem_rvalid;
      end
      if (cap) begin
        cap_dat = m_we ? '0 : bus.mem_rdata;
        if (m_owner_dm) m_dm_rdata = cap_dat; else m_if_rdata = cap_dat;
        m_resp_due = 1;
      end
    end else if (e_dm_gnt) begin
      m_active = 1; m_owner_dm = 1; m_we = bus.dm_we; m_addr = bus.dm_addr;
      m_wdata = bus.dm_wdata; m_be = bus.dm_be;
      if (bus.if_req && m_starve < LIM) m_starve++;
    end else if (e_if_gnt) begin
      m_active = 1; m_owner_dm = 0; m_we = 0; m_addr = bus.if_addr;
      m_wdata = '0; m_be = '1;
      m_starve = 0;
    end
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
    if (g_if || !bus.if_req) begin
      bus.if_req  = ($urandom_range(0, 99) < if_pct);
      bus.if_addr = $urandom;
    end
    if (g_dm || !bus.dm_req) begin
      bus.dm_req   = ($urandom_range(0, 99) < dm_pct);
      bus.dm_we    = 1'($urandom_range(0, 1));
      bus.dm_addr  = $urandom;
      bus.dm_wdata = $urandom;
      bus.dm_be    = BW'($urandom_range(0, 15));
    end
    g_if = 0; g_dm = 0;
    bus.mem_gnt = ($urandom_range(0, 99) < gnt_pct);
    case (rv_mode)
      1:       bus.mem_rvalid = m_active && m_accepted && !m_resp_due;
      2:       bus.mem_rvalid = 1'b1;
      default: bus.mem_rvalid = ($urandom_range(0, 99) < rv_pct);
    endcase
    if (rand_rdata) bus.mem_rdata = $urandom;
  endtask

  task automatic run(input int n, input int rst_pct);
    for (int i = 0; i < n; i++) begin
      check_cycle();
      drive();
      // pulse reset while a transaction is waiting on memory
      rst_n = !(rst_pct > 0 && m_active && m_accepted && !m_resp_due &&
                $urandom_range(0, 99) < rst_pct);
    end
  endtask

  task automatic clear_obs();
    t_gnt = -1; t_dmg = -1; t_mreq = -1; t_rv = -1; rd_seen = '0;
    addr_q.delete();
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_be = '0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    if_pct = 0; dm_pct = 0; gnt_pct = 100; rv_pct = 0; rv_mode = 1; rand_rdata = 0;
    cyc = 0; starve_chk = 0; seen_if = 0; run_len = 0; n_ifg = 0;
    clear_obs();
    for (int i = 0; i < 3; i++) begin check_cycle(); drive(); end
    rst_n = 1;
    run(2, 0);

    // single fetch, memory answers one cycle after accepting
    clear_obs();
    bus.mem_rdata = 32'h0000_0013;
    bus.if_req = 1; bus.if_addr = 32'h8000_0000;
    run(8, 0);
    chk("t1_mreq_lat", t_mreq - t_gnt, 1);
    chk("t1_rvalid_lat", t_rv - t_gnt, 3);
    chk("t1_rdata", rd_seen, 32'h0000_0013);

    // same-cycle gnt and rvalid
    clear_obs();
    rv_mode = 2; bus.mem_rdata = 32'h1234_5678;
    bus.if_req = 1; bus.if_addr = 32'h8000_0004;
    run(6, 0);
    chk("t6_rvalid_lat", t_rv - t_gnt, 2);
    chk("t6_rdata", rd_seen, 32'h1234_5678);

    // simultaneous fetch and data read: data first
    clear_obs();
    rv_mode = 1;
    bus.if_req = 1; bus.if_addr = 32'h8000_0008;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h0000_0100; bus.dm_be = '1;
    run(14, 0);
    chk("t2_dm_first", (t_dmg >= 0) && (t_gnt > t_dmg), 1);
    chk("t2_n_txn", addr_q.size(), 2);
    if (addr_q.size() >= 2) begin
      chk("t2_addr0", addr_q[0], 32'h0000_0100);
      chk("t2_addr1", addr_q[1], 32'h8000_0008);
    end

    // delayed mem_gnt on a write: fields held, zero rdata
    clear_obs();
    gnt_pct = 0; bus.mem_gnt = 0;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h0000_0200;
    bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_be = 4'b0011;
    run(4, 0);
    gnt_pct = 100;
    run(6, 0);
    chk("t4_dm_rdata", bus.dm_rdata, 0);

    // both requesters saturated: 4 data grants per fetch grant
    rv_mode = 2; if_pct = 100; dm_pct = 100;
    starve_chk = 1; seen_if = 0; run_len = 0; n_ifg = 0;
    run(80, 0);
    starve_chk = 0;
    chk("t3_if_grants_seen", n_ifg >= 3, 1);
    if_pct = 0; dm_pct = 0;
    run(20, 0);

    // random traffic, spurious rvalids, resets during WAIT
    rv_mode = 0; rand_rdata = 1;
    if_pct = 50;  dm_pct = 50;  gnt_pct = 50;  rv_pct = 30; run(700, 3);
    if_pct = 90;  dm_pct = 90;  gnt_pct = 30;  rv_pct = 20; run(700, 3);
    if_pct = 20;  dm_pct = 80;  gnt_pct = 80;  rv_pct = 60; run(700, 3);
    if_pct = 100; dm_pct = 100; gnt_pct = 100; rv_pct = 50; run(700, 3);
    rst_n = 1;
    run(5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
